// File: rtl/div_param.sv
// ---------------------------------------------------------------------------
// div_param -- parametrised iterative integer divider (RISC-V DIV/DIVU/REM/REMU)
//
// Restoring divider that retires STEP_BITS quotient bits per CALC cycle.
// Divide-by-zero, signed overflow and (optionally) |dividend| < |divisor|
// finish without iterating. A destination tag travels with the operation.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   start_i     request pulse, sampled only while busy_o = 0
//   kill_i      abort the in-flight operation
//   op_i        funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU (others -> DIVU)
//   dividend_i  rs1 operand
//   divisor_i   rs2 operand
//   tag_i       destination tag
//   result_o    quotient or remainder, held until the next completion
//   tag_o       tag of the completed operation
//   ready_o     one-cycle completion pulse
//   busy_o      operation in flight
// ---------------------------------------------------------------------------
module div_param #(
    parameter int DATA_W    = 32,
    parameter int STEP_BITS = 1,
    parameter int EARLY_OUT = 1,
    parameter int TAG_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic [DATA_W-1:0] result_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              ready_o,
    output logic              busy_o
);

    localparam int N     = DATA_W / STEP_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        PREP = 4'b0010,
        CALC = 4'b0100,
        FIX  = 4'b1000
    } state_t;

    state_t             state;
    logic               is_signed_r;
    logic               is_rem_r;
    logic               neg_r;
    // q_r holds the dividend on entry and shifts quotient bits in from the
    // LSB as dividend bits leave through the MSB.
    logic [DATA_W-1:0]  q_r;
    logic [DATA_W-1:0]  divisor_r;
    logic [DATA_W:0]    rem_r;
    logic [CNT_W-1:0]   count_r;
    logic [TAG_W-1:0]   tag_r;

    // Op decode; any unlisted funct3 falls through to DIVU.
    logic op_is_signed;
    logic op_is_rem;
    assign op_is_signed = (op_i == 3'b100) || (op_i == 3'b110);
    assign op_is_rem    = (op_i == 3'b110) || (op_i == 3'b111);

    // PREP: magnitudes, sign of result, special-case detection.
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              div_zero;
    logic              overflow;
    logic              early;
    logic              neg_calc;

    assign a_neg    = is_signed_r & q_r[DATA_W-1];
    assign b_neg    = is_signed_r & divisor_r[DATA_W-1];
    assign a_mag    = a_neg ? -q_r : q_r;
    assign b_mag    = b_neg ? -divisor_r : divisor_r;
    assign div_zero = (divisor_r == '0);
    assign overflow = is_signed_r && (q_r == MIN_VAL) && (divisor_r == '1);
    assign early    = (EARLY_OUT != 0) && (a_mag < b_mag);
    assign neg_calc = is_rem_r ? a_neg : (a_neg ^ b_neg);

    // CALC: STEP_BITS restoring trial subtractions chained in one cycle.
    logic [DATA_W:0]   rem_nx;
    logic [DATA_W-1:0] q_nx;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rem_nx = rem_r;
        q_nx   = q_r;
        for (int i = 0; i < STEP_BITS; i++) begin
            rem_nx = {rem_nx[DATA_W-1:0], q_nx[DATA_W-1]};
            if (rem_nx >= {1'b0, divisor_r}) begin
                rem_nx = rem_nx - {1'b0, divisor_r};
                q_nx   = {q_nx[DATA_W-2:0], 1'b1};
            end else begin
                q_nx   = {q_nx[DATA_W-2:0], 1'b0};
            end
        end
    end

    // FIX: pick quotient or remainder and apply the sign.
    logic [DATA_W-1:0] sel_val;
    logic [DATA_W-1:0] fix_val;
    assign sel_val = is_rem_r ? rem_r[DATA_W-1:0] : q_r;
    assign fix_val = neg_r ? -sel_val : sel_val;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            is_signed_r <= 1'b0;
            is_rem_r    <= 1'b0;
            neg_r       <= 1'b0;
            q_r         <= '0;
            divisor_r   <= '0;
            rem_r       <= '0;
            count_r     <= '0;
            tag_r       <= '0;
            result_o    <= '0;
            tag_o       <= '0;
            ready_o     <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            if (kill_i && (state != IDLE)) begin
                // Flush: drop the operation, keep the last result visible.
                state  <= IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i && !kill_i) begin
                            is_signed_r <= op_is_signed;
                            is_rem_r    <= op_is_rem;
                            q_r         <= dividend_i;
                            divisor_r   <= divisor_i;
                            tag_r       <= tag_i;
                            busy_o      <= 1'b1;
                            state       <= PREP;
                        end
                    end
                    PREP: begin
                        if (div_zero) begin
                            // Remainder is the raw dividend; no sign fix-up.
                            q_r   <= '1;
                            rem_r <= {1'b0, q_r};
                            neg_r <= 1'b0;
                            state <= FIX;
                        end else if (overflow) begin
                            q_r   <= q_r;
                            rem_r <= '0;
                            neg_r <= 1'b0;
                            state <= FIX;
                        end else if (early) begin
                            q_r   <= '0;
                            rem_r <= {1'b0, a_mag};
                            neg_r <= neg_calc;
                            state <= FIX;
                        end else begin
                            q_r       <= a_mag;
                            divisor_r <= b_mag;
                            rem_r     <= '0;
                            neg_r     <= neg_calc;
                            count_r   <= CNT_W'(N);
                            state     <= CALC;
                        end
                    end
                    CALC: begin
                        q_r     <= q_nx;
                        rem_r   <= rem_nx;
                        count_r <= count_r - 1'b1;
                        if (count_r == CNT_W'(1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        result_o <= fix_val;
                        tag_o    <= tag_r;
                        ready_o  <= 1'b1;
                        busy_o   <= 1'b0;
                        state    <= IDLE;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_param.sv
// ---------------------------------------------------------------------------
// tb_div_param -- directed testbench for div_param (DATA_W=32, STEP_BITS=2).
// Two instances share stimulus: dut_e with early-out enabled, dut_f without.
// ---------------------------------------------------------------------------
module tb_div_param;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        kill_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  tag_i;

    logic [31:0] result_e, result_f;
    logic [4:0]  tag_e, tag_f;
    logic        ready_e, ready_f;
    logic        busy_e, busy_f;

    div_param #(.DATA_W(32), .STEP_BITS(2), .EARLY_OUT(1), .TAG_W(5)) dut_e (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .kill_i(kill_i),
        .op_i(op_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
        .tag_i(tag_i), .result_o(result_e), .tag_o(tag_e),
        .ready_o(ready_e), .busy_o(busy_e)
    );

    div_param #(.DATA_W(32), .STEP_BITS(2), .EARLY_OUT(0), .TAG_W(5)) dut_f (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .kill_i(kill_i),
        .op_i(op_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
        .tag_i(tag_i), .result_o(result_f), .tag_o(tag_f),
        .ready_o(ready_f), .busy_o(busy_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat_e, lat_f, extra, busy_err;
    logic [31:0] res_e, res_f;
    logic [4:0]  tg_e, tg_f;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Called at a negedge; issues one op and samples both DUTs every negedge
    // until each has pulsed ready_o (bounded), then samples one extra cycle.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg);
        int cyc;
        bit de, df;
        op_i = op; dividend_i = a; divisor_i = b; tag_i = tg; start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        de = 0; df = 0; lat_e = -1; lat_f = -1; extra = 0; busy_err = 0; cyc = 0;
        while (!(de && df) && cyc < 100) begin
            if (!de) begin
                if (ready_e) begin
                    if (busy_e) busy_err++;
                    de = 1; lat_e = cyc; res_e = result_e; tg_e = tag_e;
                end else if (!busy_e) busy_err++;
            end else if (ready_e) extra++;
            if (!df) begin
                if (ready_f) begin
                    if (busy_f) busy_err++;
                    df = 1; lat_f = cyc; res_f = result_f; tg_f = tag_f;
                end else if (!busy_f) busy_err++;
            end else if (ready_f) extra++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (ready_e || ready_f) extra++;
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tg, input logic [31:0] exp,
                       input int le, input int lf);
        do_op(op, a, b, tg);
        check({name, "/res_e"}, 64'(res_e), 64'(exp));
        check({name, "/res_f"}, 64'(res_f), 64'(exp));
        check({name, "/lat_e"}, 64'(lat_e), 64'(le));
        check({name, "/lat_f"}, 64'(lat_f), 64'(lf));
        check({name, "/tag_e"}, 64'(tg_e), 64'(tg));
        check({name, "/tag_f"}, 64'(tg_f), 64'(tg));
        check({name, "/busy"}, 64'(busy_err), 64'd0);
        check({name, "/one_pulse"}, 64'(extra), 64'd0);
    endtask

    // Reference quotient/remainder built from the language operators.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic s, r;
        logic signed [31:0] sa, sb, sq;
        s = (op == OP_DIV) || (op == OP_REM);
        r = (op == OP_REM) || (op == OP_REMU);
        sa = a; sb = b;
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : a;
        if (s) begin
            sq = r ? (sa % sb) : (sa / sb);
            return sq;
        end
        return r ? (a % b) : (a / b);
    endfunction

    task automatic count_ready(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_e || ready_f) n++;
        end
    endtask

    logic [31:0] prev;
    int          nr;

    initial begin
        rst_n = 1'b0; start_i = 1'b0; kill_i = 1'b0; op_i = 3'b000;
        dividend_i = '0; divisor_i = '0; tag_i = '0;
        @(negedge clk);
        check("reset/result", 64'(result_e), 64'd0);
        check("reset/tag", 64'(tag_e), 64'd0);
        check("reset/ready", 64'(ready_e), 64'd0);
        check("reset/busy", 64'(busy_f), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors: expected values and latencies computed by hand.
        run("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          5'd3,  32'd14,         18, 18);
        run("div_m100_7",   OP_DIV,  32'hFFFF_FF9C,  32'd7,          5'd4,  32'hFFFF_FFF2,  18, 18);
        run("rem_m100_7",   OP_REM,  32'hFFFF_FF9C,  32'd7,          5'd5,  32'hFFFF_FFFE,  18, 18);
        run("remu_big_7",   OP_REMU, 32'hFFFF_FF9C,  32'd7,          5'd6,  32'd2,          18, 18);
        run("div_m100_m7",  OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd7,  32'd14,         18, 18);
        run("rem_100_m7",   OP_REM,  32'd100,        32'hFFFF_FFF9,  5'd8,  32'd2,          18, 18);
        run("badop_divu",   3'b000,  32'd100,        32'd7,          5'd9,  32'd14,         18, 18);
        run("div_by0",      OP_DIV,  32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF,   2,  2);
        run("rem_by0",      OP_REM,  32'd5,          32'd0,          5'd11, 32'd5,           2,  2);
        run("div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,   2,  2);
        run("rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,           2,  2);
        run("divu_3_10",    OP_DIVU, 32'd3,          32'd10,         5'd14, 32'd0,           2, 18);
        run("rem_m3_10",    OP_REM,  32'hFFFF_FFFD,  32'd10,         5'd15, 32'hFFFF_FFFD,   2, 18);
        run("divu_max_1",   OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF,  18, 18);

        // Kill mid-CALC: no completion, result held, restart next cycle.
        prev = result_f;
        op_i = OP_DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; tag_i = 5'd1; start_i = 1'b1;
        @(posedge clk); @(negedge clk); start_i = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        kill_i = 1'b1;
        @(posedge clk); @(negedge clk);
        kill_i = 1'b0;
        check("kill_calc/busy", 64'(busy_f), 64'd0);
        check("kill_calc/ready", 64'(ready_f), 64'd0);
        check("kill_calc/result", 64'(result_f), 64'(prev));
        run("after_kill", OP_DIVU, 32'd1000, 32'd3, 5'd2, 32'd333, 18, 18);
        count_ready(3, nr);
        check("hold/ready", 64'(nr), 64'd0);
        check("hold/result", 64'(result_f), 64'd333);
        check("hold/tag", 64'(tag_f), 64'd2);

        // Kill on the FIX cycle of the early-out path: kill wins.
        op_i = OP_DIVU; dividend_i = 32'd3; divisor_i = 32'd10; tag_i = 5'd20; start_i = 1'b1;
        @(posedge clk); @(negedge clk); start_i = 1'b0;
        @(posedge clk); @(negedge clk);
        kill_i = 1'b1;
        @(posedge clk); @(negedge clk);
        kill_i = 1'b0;
        check("kill_fix/ready", 64'(ready_e), 64'd0);
        check("kill_fix/busy", 64'(busy_e), 64'd0);
        check("kill_fix/result", 64'(result_e), 64'd333);
        count_ready(20, nr);
        check("kill_fix/no_ready", 64'(nr), 64'd0);

        // kill together with start in IDLE: start ignored.
        op_i = OP_DIVU; dividend_i = 32'd50; divisor_i = 32'd5; start_i = 1'b1; kill_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0; kill_i = 1'b0;
        check("kill_start/busy", 64'(busy_e), 64'd0);
        count_ready(20, nr);
        check("kill_start/no_ready", 64'(nr), 64'd0);

        // Reset mid-CALC: outputs clear at once, nothing completes afterwards.
        op_i = OP_DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; tag_i = 5'd7; start_i = 1'b1;
        @(posedge clk); @(negedge clk); start_i = 1'b0;
        repeat (6) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        check("rst_mid/result", 64'(result_f), 64'd0);
        check("rst_mid/tag", 64'(tag_f), 64'd0);
        check("rst_mid/busy", 64'({busy_e, busy_f}), 64'd0);
        check("rst_mid/ready", 64'({ready_e, ready_f}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_ready(25, nr);
        check("rst_mid/no_ready", 64'(nr), 64'd0);
        run("after_rst", OP_REMU, 32'd1000, 32'd3, 5'd17, 32'd1, 18, 18);

        // Random ops against the operator-based reference.
        for (int k = 0; k < 200; k++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb, ma, mb;
            logic        s, special;
            int          le, lf;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 4))
                0: rb = rb >> $urandom_range(0, 31);
                1: ra = ra >> $urandom_range(0, 31);
                2: rb = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF;
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            s  = (rop == OP_DIV) || (rop == OP_REM);
            ma = (s && ra[31]) ? -ra : ra;
            mb = (s && rb[31]) ? -rb : rb;
            special = (rb == 32'd0) || (s && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF);
            lf = special ? 2 : 18;
            le = (special || ma < mb) ? 2 : 18;
            do_op(rop, ra, rb, 5'(k));
            check("rnd/res_e", 64'(res_e), 64'(model(rop, ra, rb)));
            check("rnd/res_f", 64'(res_f), 64'(model(rop, ra, rb)));
            check("rnd/lat_e", 64'(lat_e), 64'(le));
            check("rnd/lat_f", 64'(lat_f), 64'(lf));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
